op_sram_drain: RTL

OP_SRAM_DRAIN -- requirements
Module: op_sram_drain

---
 rtl/op_drain_pkg.sv | 16 +
 rtl/word_serializer.sv | 30 +++
 rtl/op_sram_drain.sv | 108 ++++++++++
 3 files changed

// File: rtl/op_drain_pkg.sv
// op_drain_pkg: shared state encoding and default sizing
// for the output-SRAM drain block.
package op_drain_pkg;

  localparam int NUM_WORDS = 16;
  localparam int WORD_W    = 128;
  localparam int BEAT_W    = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT,
    SEND
  } state_t;

endpackage

// File: rtl/word_serializer.sv
// word_serializer: holds one SRAM word and presents it
// as BEAT_W slices, beat 0 being the least significant.
module word_serializer #(
  parameter int WORD_W = 128,
  parameter int BEAT_W = 32,
  parameter int BW     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] d,
  input  logic              valid,
  input  logic [BW-1:0]     beat,
  output logic [BEAT_W-1:0] data
);

  logic [WORD_W-1:0] hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold <= '0;
    end else if (load) begin
      hold <= d;
    end
  end

  // Slice comes only from registers, so it stays put under backpressure.
  assign data = valid ? hold[int'(beat)*BEAT_W +: BEAT_W] : '0;

endmodule

// File: rtl/op_sram_drain.sv
// op_sram_drain: reads every output-SRAM word in turn and
// streams it out as valid/ready beats.
module op_sram_drain
  import op_drain_pkg::*;
#(
  parameter int NUM_WORDS = op_drain_pkg::NUM_WORDS,
  parameter int WORD_W    = op_drain_pkg::WORD_W,
  parameter int BEAT_W    = op_drain_pkg::BEAT_W,
  localparam int AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int BEATS = WORD_W / BEAT_W,
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     op_addr,
  output logic              op_cen,
  output logic              op_wen,
  input  logic [WORD_W-1:0] op_q,
  output logic [BEAT_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam logic [AW-1:0] LAST_W = AW'(NUM_WORDS - 1);
  localparam logic [BW-1:0] LAST_B = BW'(BEATS - 1);

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] word_cnt;
  logic [BW-1:0] beat_cnt;
  logic          done_q;
  logic          hs;
  logic          last_beat;
  logic          last_word;

  assign hs        = (state == SEND) && m_ready;
  assign last_beat = (beat_cnt == LAST_B);
  assign last_word = (word_cnt == LAST_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = READ;
      READ: state_nx = WAIT;
      WAIT: state_nx = SEND;
      SEND: begin
        if (hs && last_beat) begin
          state_nx = last_word ? IDLE : READ;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Word counter returns to 0 after the last word: no wrap past it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_cnt <= '0;
      beat_cnt <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= hs && last_beat && last_word;
      if (hs) begin
        if (last_beat) begin
          beat_cnt <= '0;
          word_cnt <= last_word ? '0 : word_cnt + 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

  assign busy    = (state != IDLE);
  assign done    = done_q;
  assign op_cen  = (state != READ);
  assign op_wen  = 1'b1;
  assign op_addr = word_cnt;
  assign m_valid = (state == SEND);
  assign m_last  = m_valid && last_beat && last_word;

  word_serializer #(
    .WORD_W (WORD_W),
    .BEAT_W (BEAT_W),
    .BW     (BW)
  ) u_ser (
    .clk   (clk),
    .reset (reset),
    .load  (state == WAIT),
    .d     (op_q),
    .valid (m_valid),
    .beat  (beat_cnt),
    .data  (m_data)
  );

endmodule
